// File: rtl/fpa_pipe_param.sv
// Pipelined IEEE-754 add/subtract with generic exponent/fraction widths, RNE rounding,
// full special-value handling and a stall-all valid/ready stream interface.
module fpa_pipe_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] c,
    output logic                 flg_inv,
    output logic                 flg_ovf,
    output logic                 flg_inx
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int XW = EXP_W + $clog2(MAN_W + 4) + 2;
    localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_MAXE = XW'((1 << EXP_W) - 1);

    logic [5:0]       r_vld;
    logic             w_en;
    logic [W-1:0]     r0_a, r0_b;
    logic             r0_sub;
    logic [3:0]       r_spec, r_sinv;
    logic [W-1:0]     r_sc [4];
    logic [W-1:0]     r_c;
    logic             r_inv, r_ovf, r_inx;

    assign w_en      = ~r_vld[5] | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld[5];
    assign c         = r_c;
    assign flg_inv   = r_inv;
    assign flg_ovf   = r_ovf;
    assign flg_inx   = r_inx;

    // S1: classify both operands; index 0 is A, index 1 is B with effective sign
    logic [W-1:0]     w_op  [2];
    logic [EXP_W-1:0] w_eff [2];
    logic [M:0]       w_sig [2];
    logic [1:0]       w_sgn, w_nan, w_snan, w_inf;
    logic             w_spec, w_sinv, w_inf_clash;
    logic [W-1:0]     w_sc;

    assign w_op[0] = r0_a;
    assign w_op[1] = r0_b;
    assign w_sgn   = {r0_b[W-1] ^ r0_sub, r0_a[W-1]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [EXP_W-1:0] w_fld;
            assign w_fld       = w_op[gi][M +: EXP_W];
            assign w_nan[gi]   = (&w_fld) & (|w_op[gi][M-1:0]);
            assign w_snan[gi]  = w_nan[gi] & ~w_op[gi][M-1];
            assign w_inf[gi]   = (&w_fld) & ~(|w_op[gi][M-1:0]);
            assign w_eff[gi]   = (|w_fld) ? w_fld : EXP_W'(1);
            assign w_sig[gi]   = {|w_fld, w_op[gi][M-1:0]};
        end
    endgenerate

    assign w_inf_clash = (&w_inf) & (w_sgn[0] ^ w_sgn[1]);
    assign w_spec      = (|w_nan) | (|w_inf);
    assign w_sinv      = (|w_snan) | w_inf_clash;
    assign w_sc        = ((|w_nan) | w_inf_clash) ? QNAN :
                         w_inf[0] ? {w_sgn[0], {EXP_W{1'b1}}, {M{1'b0}}} :
                                    {w_sgn[1], {EXP_W{1'b1}}, {M{1'b0}}};

    // S2: order by magnitude so the subtraction below can never go negative
    logic [1:0]       r1_sgn;
    logic [EXP_W-1:0] r1_ea, r1_eb;
    logic [M:0]       r1_ma, r1_mb;
    logic             w_swap;
    assign w_swap = {r1_eb, r1_mb} > {r1_ea, r1_ma};

    // S3: align Y into guard/round/sticky positions
    logic             r2_sx, r2_esub;
    logic [EXP_W-1:0] r2_ex, r2_d;
    logic [M:0]       r2_mx, r2_my;
    logic [SW-1:0]    w_ye, w_sh3, w_lost, w_al;

    always_comb begin
        w_ye   = {r2_my, 3'b000};
        w_sh3  = w_ye >> r2_d;
        w_lost = w_ye & ~({SW{1'b1}} << r2_d);
        if (XW'(r2_d) >= XW'(M + 3))
            w_al = {{(SW-1){1'b0}}, |r2_my};
        else
            w_al = {w_sh3[SW-1:1], w_sh3[0] | (|w_lost)};
    end

    // S4: magnitude add or subtract
    logic             r3_sx, r3_esub;
    logic [EXP_W-1:0] r3_ex;
    logic [SW-1:0]    r3_xe, r3_ye;
    logic [SW:0]      w_sum;
    assign w_sum = r3_esub ? ({1'b0, r3_xe} - {1'b0, r3_ye}) : ({1'b0, r3_xe} + {1'b0, r3_ye});

    // S5: normalise, round to nearest even, pack
    logic             r4_sx, r4_esub;
    logic [EXP_W-1:0] r4_ex;
    logic [SW:0]      r4_sum;
    logic [SW-1:0]    w_m, w_mn;
    logic [XW-1:0]    w_e, w_lz, w_sh, w_e2, w_ef;
    logic [M+1:0]     w_rnd;
    logic             w_up, w_ovf, w_inx;
    logic [W-1:0]     w_res;

    always_comb begin
        w_m = r4_sum[SW-1:0];
        w_e = XW'(r4_ex);
        if (r4_sum[SW]) begin
            w_m = {r4_sum[SW:2], r4_sum[1] | r4_sum[0]};
            w_e = XW'(r4_ex) + X_ONE;
        end
        w_lz = XW'(SW);
        for (int i = 0; i < SW; i++)
            if (w_m[i]) w_lz = XW'(SW - 1 - i);
        // never shift below exponent 1; whatever remains unnormalised is subnormal
        w_sh  = (w_lz < w_e - X_ONE) ? w_lz : w_e - X_ONE;
        w_mn  = w_m << w_sh;
        w_e2  = w_e - w_sh;
        w_up  = w_mn[2] & (w_mn[1] | w_mn[0] | w_mn[3]);
        w_rnd = {1'b0, w_mn[SW-1:3]} + {{(M+1){1'b0}}, w_up};
        w_ef  = '0;
        if (w_rnd[M+1])
            w_ef = w_e2 + X_ONE;
        else if (w_rnd[M])
            w_ef = w_e2;
        w_inx = |w_mn[2:0];
        w_ovf = 1'b0;
        w_res = {r4_sx, w_ef[EXP_W-1:0], (w_rnd[M+1] ? w_rnd[M:1] : w_rnd[M-1:0])};
        if (w_ef >= X_MAXE) begin
            w_res = {r4_sx, {EXP_W{1'b1}}, {M{1'b0}}};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end
        if (r4_sum == '0) begin
            w_res = {~r4_esub & r4_sx, {(W-1){1'b0}}};
            w_inx = 1'b0;
            w_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_inv <= 1'b0;
            r_ovf <= 1'b0;
            r_inx <= 1'b0;
        end else if (w_en) begin
            r_vld   <= {r_vld[4:0], in_valid};
            r0_a    <= a;
            r0_b    <= b;
            r0_sub  <= sub;
            r1_sgn  <= w_sgn;
            r1_ea   <= w_eff[0];
            r1_eb   <= w_eff[1];
            r1_ma   <= w_sig[0];
            r1_mb   <= w_sig[1];
            r_spec  <= {r_spec[2:0], w_spec};
            r_sinv  <= {r_sinv[2:0], w_sinv};
            r_sc[0] <= w_sc;
            for (int i = 1; i < 4; i++)
                r_sc[i] <= r_sc[i-1];
            r2_sx   <= w_swap ? r1_sgn[1] : r1_sgn[0];
            r2_esub <= r1_sgn[1] ^ r1_sgn[0];
            r2_ex   <= w_swap ? r1_eb : r1_ea;
            r2_mx   <= w_swap ? r1_mb : r1_ma;
            r2_my   <= w_swap ? r1_ma : r1_mb;
            r2_d    <= w_swap ? (r1_eb - r1_ea) : (r1_ea - r1_eb);
            r3_sx   <= r2_sx;
            r3_esub <= r2_esub;
            r3_ex   <= r2_ex;
            r3_xe   <= {r2_mx, 3'b000};
            r3_ye   <= w_al;
            r4_sx   <= r3_sx;
            r4_esub <= r3_esub;
            r4_ex   <= r3_ex;
            r4_sum  <= w_sum;
            if (r_vld[4]) begin
                r_c   <= r_spec[3] ? r_sc[3] : w_res;
                r_inv <= r_spec[3] & r_sinv[3];
                r_ovf <= ~r_spec[3] & w_ovf;
                r_inx <= ~r_spec[3] & w_inx;
            end
        end
    end

endmodule

// File: tb/tb_fpa_pipe_param.sv
// Scoreboard bench for fpa_pipe_param: directed fp32 vectors, latency, stall and reset behaviour.
module tb_fpa_pipe_param;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] c;
    logic         flg_inv, flg_ovf, flg_inx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;
    logic [W+2:0] sb_q [$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] c;
        logic [2:0]  f;   // {inv, ovf, inx}
    } vec_t;
    vec_t vt [14];

    fpa_pipe_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flg_inv(flg_inv), .flg_ovf(flg_ovf), .flg_inx(flg_inx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation for every output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got c=%h flags=%b, required no output", c, {flg_inv, flg_ovf, flg_inx});
            end else begin
                logic [W+2:0] req;
                req = sb_q.pop_front();
                if ({c, flg_inv, flg_ovf, flg_inx} !== req) begin
                    errors++;
                    $display("FAIL result_%0d: got c=%h flags=%b, required c=%h flags=%b",
                             n_out, c, {flg_inv, flg_ovf, flg_inx}, req[W+2:3], req[2:0]);
                end else begin
                    $display("result %0d: c=%h inv=%b ovf=%b inx=%b", n_out, c, flg_inv, flg_ovf, flg_inx);
                end
            end
            n_out++;
        end
    end

    // Present one operation (caller at posedge+1); returns the cycle index of the accepting edge.
    task automatic send(input vec_t v, output int acc);
        int k;
        a = v.a; b = v.b; sub = v.s; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b, required 1", in_ready);
            acc = -1;
        end else begin
            sb_q.push_back({v.c, v.f});
            acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(nm, sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int acc, k, n0;
        logic seen;
        vt[0]  = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000};
        vt[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
        vt[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
        vt[3]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000};
        vt[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
        vt[5]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001};
        vt[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
        vt[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
        vt[8]  = '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100};
        vt[9]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000};
        vt[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
        vt[11] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
        vt[12] = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000};
        vt[13] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_c", c, 0);
        chk("reset_flags", {flg_inv, flg_ovf, flg_inx}, 0);
        chk("reset_in_ready", in_ready, 1);

        @(posedge clk); #1;
        send(vt[0], acc);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", cyc - acc, 5);
        drain("drain_first");

        @(posedge clk); #1;
        for (int i = 1; i < 14; i++) send(vt[i], acc);
        drain("drain_vectors");

        // Back-to-back stream with a three-cycle output stall in the middle.
        @(posedge clk); #1;
        n0 = n_out;
        fork
            begin
                int acc_a;
                for (int i = 0; i < 8; i++) send(vt[i], acc_a);
            end
            begin
                int kb;
                logic [W-1:0] hold_c;
                kb = 0;
                @(negedge clk);
                while (!out_valid && kb < 50) begin
                    @(negedge clk);
                    kb++;
                end
                chk("pre_stall_in_ready", in_ready, 1);
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                hold_c = c;
                chk("stall_in_ready_0", in_ready, 0);
                for (int j = 1; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_c_stable", c, hold_c);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                chk("post_stall_in_ready", in_ready, 1);
            end
        join
        drain("drain_stream");
        chk("stream_count", n_out - n0, 8);

        // Reset with operations in flight; the oldest would surface on the reset edge.
        @(posedge clk); #1;
        n0 = n_out;
        for (int i = 0; i < 5; i++) send(vt[i], acc);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        seen = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("no_stale_result", seen, 0);
        chk("rst_out_count", n_out - n0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
